// File: rtl/uart_rx_byte.sv
// UART byte receiver: synchronises the serial line, samples each bit at the centre using
// half-bit ticks from an external baud generator, and hands bytes out on a valid/ready port.
module uart_rx_byte #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int   HW      = $clog2(2 * DATA_BITS + 6);
    localparam int   BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_d, fall;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d;
    logic                   pflag_q, pflag_d;
    logic                   centre;
    logic                   ferr_d, perr_d;
    logic                   dlv_q, dlv_d;

    // Synchroniser and edge register reset to 1 so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rxs_d  <= rxs;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_d & ~rxs;

    // Ticks arrive every half bit; only the odd-numbered ones land on a bit centre.
    assign centre = clk_bps & ~hcnt_q[0];

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        pflag_d = pflag_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        dlv_d   = 1'b0;

        if ((state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) && clk_bps)
            hcnt_d = hcnt_q + HW'(1);

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    pflag_d = 1'b0;
                end
            end
            START: begin
                if (centre)
                    state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (centre) begin
                    sr_d   = {rxs, sr_q[DATA_BITS-1:1]};
                    bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (centre) begin
                    pflag_d = (rxs != ((^sr_q) ^ PAR_ODD));
                    state_d = STOP;
                end
            end
            STOP: begin
                if (centre) begin
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HI;
                    end else if (pflag_q) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dlv_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must go high before another start can be seen.
                if (rxs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            bcnt_q     <= '0;
            sr_q       <= '0;
            pflag_q    <= 1'b0;
            dlv_q      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bps_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            bcnt_q     <= bcnt_d;
            sr_q       <= sr_d;
            pflag_q    <= pflag_d;
            dlv_q      <= dlv_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            bps_start  <= (state_d == START) || (state_d == DATA) ||
                          (state_d == PARITY) || (state_d == STOP);
        end
    end

    // The shift register is untouched until the next frame's data bits, so it is read here directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (dlv_q) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= sr_q;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: an 8N1 receiver and an even-parity receiver, each fed by a
// behavioural half-bit tick generator; delivered bytes are checked against a scoreboard.
module tb_uart_rx_byte;

    localparam int H = 24;
    localparam int B = 2 * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1, line_p = 1'b1;
    logic       clk_bps = 1'b0, clk_bps_p = 1'b0;
    logic       bps, bps_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       rx_ready = 1'b1, rx_ready_p = 1'b1;
    logic       rx_busy, rx_busy_p;
    logic       frame_err, frame_err_p, parity_err, parity_err_p, overrun, overrun_p;

    int n_tests = 0;
    int n_fail  = 0;

    // written only by the monitor
    logic [7:0] obs_q[$], obs_q_p[$];
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    int n_ferr_p = 0, n_perr_p = 0, n_ovr_p = 0;
    int cyc = 0, tick_cnt = 0, stop_tick_cyc = -100, valid_rise_cyc = -200;
    logic prev_valid = 1'b0;

    // written only by the test sequence
    logic [7:0] exp_q[$], exp_q_p[$];
    int rd = 0, rd_p = 0;

    uart_rx_byte #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(line), .clk_bps(clk_bps), .bps_start(bps),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    uart_rx_byte #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .uart_rx(line_p), .clk_bps(clk_bps_p), .bps_start(bps_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p), .rx_busy(rx_busy_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
    );

    always #5 clk = ~clk;

    int bcnt = 0, bcnt_p = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bps) begin bcnt <= 0; clk_bps <= 1'b0; end
        else if (bcnt == H - 1) begin bcnt <= 0; clk_bps <= 1'b1; end
        else begin bcnt <= bcnt + 1; clk_bps <= 1'b0; end
        if (!bps_p) begin bcnt_p <= 0; clk_bps_p <= 1'b0; end
        else if (bcnt_p == H - 1) begin bcnt_p <= 0; clk_bps_p <= 1'b1; end
        else begin bcnt_p <= bcnt_p + 1; clk_bps_p <= 1'b0; end
    end

    always @(negedge clk) begin
        if (rx_valid && rx_ready) obs_q.push_back(rx_data);
        if (rx_valid_p && rx_ready_p) obs_q_p.push_back(rx_data_p);
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (overrun) n_ovr++;
        if (frame_err_p) n_ferr_p++;
        if (parity_err_p) n_perr_p++;
        if (overrun_p) n_ovr_p++;
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
        if (!bps) tick_cnt = 0;
        else if (clk_bps) begin
            tick_cnt++;
            if (tick_cnt == 19) stop_tick_cyc = cyc;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel_p, input logic v);
        if (sel_p) line_p = v;
        else line = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit sel_p, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        set_line(sel_p, 1'b0);
        wait_clk(B);
        for (int i = 0; i < 8; i++) begin
            set_line(sel_p, d[i]);
            wait_clk(B);
        end
        if (has_par) begin
            set_line(sel_p, par_bit);
            wait_clk(B);
        end
        set_line(sel_p, stop_bit);
        wait_clk(B);
    endtask

    // Pops the expected byte for every byte the monitor saw accepted, then checks none is outstanding.
    task automatic scoreboard_drain(input string nm, input bit sel_p);
        logic [7:0] got, want;
        if (!sel_p) begin
            while (rd < obs_q.size()) begin
                got = obs_q[rd]; rd++; n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL %s unexpected byte got=%h required=none", nm, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++; $display("FAIL %s rx_data got=%h required=%h", nm, got, want);
                    end
                end
            end
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++; $display("FAIL %s missing bytes got=%0d required=0", nm, exp_q.size());
                exp_q.delete();
            end
        end else begin
            while (rd_p < obs_q_p.size()) begin
                got = obs_q_p[rd_p]; rd_p++; n_tests++;
                if (exp_q_p.size() == 0) begin
                    n_fail++; $display("FAIL %s unexpected byte got=%h required=none", nm, got);
                end else begin
                    want = exp_q_p.pop_front();
                    if (got !== want) begin
                        n_fail++; $display("FAIL %s rx_data got=%h required=%h", nm, got, want);
                    end
                end
            end
            n_tests++;
            if (exp_q_p.size() != 0) begin
                n_fail++; $display("FAIL %s missing bytes got=%0d required=0", nm, exp_q_p.size());
                exp_q_p.delete();
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] o;
        rst_n = 1'b0;
        wait_clk(3);
        o = {bps, rx_valid, rx_data, rx_busy, frame_err, parity_err, overrun};
        n_tests++;
        if (o !== 14'h0) begin n_fail++; $display("FAIL reset_outputs got=%h required=0", o); end
        o = {bps_p, rx_valid_p, rx_data_p, rx_busy_p, frame_err_p, parity_err_p, overrun_p};
        n_tests++;
        if (o !== 14'h0) begin n_fail++; $display("FAIL reset_outputs_p got=%h required=0", o); end
        rst_n = 1'b1;
        wait_clk(5);
        n_tests++;
        if ({bps, rx_busy, rx_valid} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset got=%b required=000", {bps, rx_busy, rx_valid});
        end
    endtask

    task automatic test_basic();
        int e0;
        e0 = n_ferr + n_perr + n_ovr;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(6 * B);
                n_tests++;
                if ({bps, rx_busy} !== 2'b11) begin
                    n_fail++; $display("FAIL basic_mid_frame bps/busy got=%b required=11", {bps, rx_busy});
                end
            end
        join
        wait_clk(10);
        n_tests++;
        if (bps !== 1'b0) begin n_fail++; $display("FAIL basic_bps_after got=%b required=0", bps); end
        n_tests++;
        if (n_ferr + n_perr + n_ovr - e0 != 0) begin
            n_fail++; $display("FAIL basic_err_pulses got=%0d required=0", n_ferr + n_perr + n_ovr - e0);
        end
        n_tests++;
        if (valid_rise_cyc - stop_tick_cyc != 2) begin
            n_fail++; $display("FAIL basic_latency got=%0d required=2", valid_rise_cyc - stop_tick_cyc);
        end
        scoreboard_drain("basic", 1'b0);
    endtask

    task automatic test_glitch();
        int e0, o0;
        e0 = n_ferr + n_perr + n_ovr;
        o0 = obs_q.size();
        line = 1'b0;
        wait_clk(H / 2);
        n_tests++;
        if (bps !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen got=%b required=1", bps); end
        line = 1'b1;
        wait_clk(3 * H);
        n_tests++;
        if ({bps, rx_busy} !== 2'b00) begin
            n_fail++; $display("FAIL glitch_idle bps/busy got=%b required=00", {bps, rx_busy});
        end
        n_tests++;
        if ((n_ferr + n_perr + n_ovr - e0 != 0) || (obs_q.size() != o0)) begin
            n_fail++; $display("FAIL glitch_no_output got=%0d events required=0",
                               n_ferr + n_perr + n_ovr - e0 + obs_q.size() - o0);
        end
    endtask

    task automatic test_frame_err();
        int f0, o0;
        f0 = n_ferr;
        o0 = obs_q.size();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_clk(3 * B);
        n_tests++;
        if ({rx_busy, bps} !== 2'b10) begin
            n_fail++; $display("FAIL ferr_wait_hi busy/bps got=%b required=10", {rx_busy, bps});
        end
        n_tests++;
        if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL ferr_count got=%0d required=1", n_ferr - f0); end
        n_tests++;
        if (obs_q.size() != o0 || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ferr_no_valid got=%b required=0", rx_valid);
        end
        line = 1'b1;
        wait_clk(10);
        n_tests++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release got=%b required=0", rx_busy); end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_clk(10);
        scoreboard_drain("ferr_recover", 1'b0);
        n_tests++;
        if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL ferr_single got=%0d required=1", n_ferr - f0); end
    endtask

    task automatic test_back_to_back();
        int v0, o0;
        v0 = n_ovr;
        o0 = obs_q.size();
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_clk(10);
        n_tests++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
            n_fail++; $display("FAIL ovr_hold valid/data got=%b/%h required=1/11", rx_valid, rx_data);
        end
        n_tests++;
        if (n_ovr - v0 != 1) begin n_fail++; $display("FAIL ovr_count got=%0d required=1", n_ovr - v0); end
        n_tests++;
        if (obs_q.size() != o0) begin
            n_fail++; $display("FAIL ovr_no_accept got=%0d required=0", obs_q.size() - o0);
        end
        rx_ready = 1'b1;
        wait_clk(5);
        n_tests++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear got=%b required=0", rx_valid); end
        scoreboard_drain("ovr_accept", 1'b0);
    endtask

    task automatic test_parity();
        int p0, f0, o0;
        p0 = n_perr_p;
        f0 = n_ferr_p;
        o0 = obs_q_p.size();
        rx_ready_p = 1'b1;
        // 0x07 has three ones, so even parity needs a 1: sending 0 must be flagged.
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_clk(10);
        n_tests++;
        if (n_perr_p - p0 != 1) begin n_fail++; $display("FAIL parity_err_count got=%0d required=1", n_perr_p - p0); end
        n_tests++;
        if (obs_q_p.size() != o0 || rx_valid_p !== 1'b0 || n_ferr_p != f0) begin
            n_fail++; $display("FAIL parity_discard valid=%b ferr=%0d required=0/0", rx_valid_p, n_ferr_p - f0);
        end
        exp_q_p.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        scoreboard_drain("parity_good", 1'b1);
        n_tests++;
        if (n_perr_p - p0 != 1) begin n_fail++; $display("FAIL parity_good_no_err got=%0d required=1", n_perr_p - p0); end
    endtask

    task automatic test_reset_mid();
        int e0, o0;
        logic [13:0] o;
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(5 * B + H);
                rst_n = 1'b0;
                wait_clk(2);
                o = {bps, rx_valid, rx_data, rx_busy, frame_err, parity_err, overrun};
                n_tests++;
                if (o !== 14'h0) begin n_fail++; $display("FAIL midreset_outputs got=%h required=0", o); end
                wait_clk(3);
                rst_n = 1'b1;
            end
        join
        e0 = n_ferr + n_perr + n_ovr;
        o0 = obs_q.size();
        wait_clk(3 * B);
        n_tests++;
        if ((n_ferr + n_perr + n_ovr != e0) || (obs_q.size() != o0) || rx_valid !== 1'b0 || bps !== 1'b0) begin
            n_fail++; $display("FAIL midreset_quiet valid=%b bps=%b required=0/0", rx_valid, bps);
        end
        rd = obs_q.size();
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_clk(10);
        scoreboard_drain("midreset_next", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
